// File: rtl/phase_acc_pkg.sv
// Shared constants and types for the phase accumulator: default word width,
// config register map, CTRL bit positions and the streaming state encoding.
package phase_acc_pkg;

  parameter int PA_WIDTH = 32;

  localparam logic [1:0] ADR_FREQ  = 2'd0;
  localparam logic [1:0] ADR_PHASE = 2'd1;
  localparam logic [1:0] ADR_STEP  = 2'd2;
  localparam logic [1:0] ADR_CTRL  = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_SWEEP_BIT = 1;
  localparam int CTRL_CLR_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/phase_acc_cfg.sv
// Config register file: FREQ/PHASE/STEP words, EN/SWEEP control bits and a
// one-cycle CLR strobe decoded from a CTRL write.
module phase_acc_cfg
  import phase_acc_pkg::*;
#(
  parameter int WIDTH = PA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cfg_dat_i,
  input  logic [1:0]       cfg_adr_i,
  input  logic             cfg_req_i,
  input  logic             sweep_adv_i,
  output logic             cfg_ack_o,
  output logic [WIDTH-1:0] freq_o,
  output logic [WIDTH-1:0] phase_o,
  output logic [WIDTH-1:0] step_o,
  output logic             en_o,
  output logic             sweep_o,
  output logic             clr_o
);

  logic             ack_q;
  logic [WIDTH-1:0] freq_q, freq_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             en_q, en_d;
  logic             sweep_q, sweep_d;
  logic             wr_s;

  assign wr_s = cfg_req_i & ack_q;

  // Next-state of the register file; a FREQ write takes priority over the sweep step.
  always_comb begin
    freq_d  = freq_q;
    phase_d = phase_q;
    step_d  = step_q;
    en_d    = en_q;
    sweep_d = sweep_q;
    clr_o   = 1'b0;
    if (sweep_adv_i && sweep_q) begin
      freq_d = freq_q + step_q;
    end else begin
      freq_d = freq_q;
    end
    if (wr_s) begin
      case (cfg_adr_i)
        ADR_FREQ:  freq_d  = cfg_dat_i;
        ADR_PHASE: phase_d = cfg_dat_i;
        ADR_STEP:  step_d  = cfg_dat_i;
        ADR_CTRL: begin
          en_d    = cfg_dat_i[CTRL_EN_BIT];
          sweep_d = cfg_dat_i[CTRL_SWEEP_BIT];
          clr_o   = cfg_dat_i[CTRL_CLR_BIT];
        end
        default: begin
          en_d = en_q;
        end
      endcase
    end else begin
      clr_o = 1'b0;
    end
  end

  // Register file state; ack comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      freq_q  <= {WIDTH{1'b0}};
      phase_q <= {WIDTH{1'b0}};
      step_q  <= {WIDTH{1'b0}};
      en_q    <= 1'b0;
      sweep_q <= 1'b0;
    end else begin
      ack_q   <= 1'b1;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      en_q    <= en_d;
      sweep_q <= sweep_d;
    end
  end

  assign cfg_ack_o = ack_q;
  assign freq_o    = freq_q;
  assign phase_o   = phase_q;
  assign step_o    = step_q;
  assign en_o      = en_q;
  assign sweep_o   = sweep_q;

endmodule

// File: rtl/phase_acc.sv
// Phase accumulator streaming angle words over a req/ack channel, with
// optional frequency sweep and a clear strobe; config via phase_acc_cfg.
module phase_acc
  import phase_acc_pkg::*;
#(
  parameter int WIDTH = PA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] t_cfg_dat,
  input  logic [1:0]       t_cfg_adr,
  input  logic             t_cfg_req,
  output logic             t_cfg_ack,
  output logic [WIDTH-1:0] i_angle_dat,
  output logic             i_angle_req,
  input  logic             i_angle_ack
);

  logic [WIDTH-1:0] freq_s, phase_s, step_s;
  logic             en_s, sweep_s, clr_s;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             req_q, req_d;
  logic             xfer_s;
  logic [WIDTH-1:0] acc_adv_s, dat_adv_s, dat_entry_s;

  phase_acc_cfg #(.WIDTH(WIDTH)) u_cfg (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_dat_i   (t_cfg_dat),
    .cfg_adr_i   (t_cfg_adr),
    .cfg_req_i   (t_cfg_req),
    .sweep_adv_i (xfer_s),
    .cfg_ack_o   (t_cfg_ack),
    .freq_o      (freq_s),
    .phase_o     (phase_s),
    .step_o      (step_s),
    .en_o        (en_s),
    .sweep_o     (sweep_s),
    .clr_o       (clr_s)
  );

  assign xfer_s      = req_q & i_angle_ack;
  assign acc_adv_s   = acc_q + freq_s;
  assign dat_adv_s   = acc_adv_s + phase_s;
  assign dat_entry_s = acc_q + phase_s;

  // State machine, accumulator and output word; CLR overrides any advance.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dat_d   = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (en_s) begin
          state_d = ST_RUN;
          dat_d   = dat_entry_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (xfer_s) begin
          acc_d   = acc_adv_s;
          dat_d   = dat_adv_s;
          state_d = en_s ? ST_RUN : ST_IDLE;
        end else begin
          state_d = en_s ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A stalled word must never change, so CLR only reloads dat when it is free.
    if (clr_s) begin
      acc_d = {WIDTH{1'b0}};
      if (!req_q || xfer_s) begin
        dat_d = phase_s;
      end else begin
        dat_d = dat_q;
      end
    end else begin
      acc_d = acc_d;
    end
    req_d = (state_d != ST_IDLE);
  end

  // Datapath and state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= {WIDTH{1'b0}};
      dat_q   <= {WIDTH{1'b0}};
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
    end
  end

  assign i_angle_dat = dat_q;
  assign i_angle_req = req_q;

endmodule

// File: tb/tb_phase_acc.sv
// Directed self-checking bench for phase_acc: streaming, stall, sweep,
// wrap, drain/clear and asynchronous reset scenarios.
module tb_phase_acc;
  import phase_acc_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] t_cfg_dat;
  logic [1:0]  t_cfg_adr;
  logic        t_cfg_req;
  logic        t_cfg_ack;
  logic [31:0] i_angle_dat;
  logic        i_angle_req;
  logic        i_angle_ack;

  int n_cmp = 0;
  int n_err = 0;

  phase_acc #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .t_cfg_dat   (t_cfg_dat),
    .t_cfg_adr   (t_cfg_adr),
    .t_cfg_req   (t_cfg_req),
    .t_cfg_ack   (t_cfg_ack),
    .i_angle_dat (i_angle_dat),
    .i_angle_req (i_angle_req),
    .i_angle_ack (i_angle_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] adr, input logic [31:0] dat);
    t_cfg_adr = adr;
    t_cfg_dat = dat;
    t_cfg_req = 1'b1;
    step();
    t_cfg_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n     = 1'b0;
    t_cfg_dat   = 32'h0;
    t_cfg_adr   = 2'd0;
    t_cfg_req   = 1'b0;
    i_angle_ack = 1'b1;
    step();
    check("rst_ack", {31'h0, t_cfg_ack}, 32'h0);
    check("rst_req", {31'h0, i_angle_req}, 32'h0);
    check("rst_dat", i_angle_dat, 32'h0);
    reset_n = 1'b1;
    step();
    check("ack_after_rel", {31'h0, t_cfg_ack}, 32'h1);

    // Basic streaming with ack tied high
    cfg_write(ADR_FREQ, 32'h56789abc);
    cfg_write(ADR_CTRL, 32'h1);
    check("req_lag", {31'h0, i_angle_req}, 32'h0);
    step();
    check("req_rise", {31'h0, i_angle_req}, 32'h1);
    check("stream0", i_angle_dat, 32'h00000000);
    step();
    check("stream1", i_angle_dat, 32'h56789abc);
    step();
    check("stream2", i_angle_dat, 32'hacf13578);
    step();
    check("stream3", i_angle_dat, 32'h0369d034);

    // Stall for three cycles, then resume
    i_angle_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", {31'h0, i_angle_req}, 32'h1);
      check("stall_dat", i_angle_dat, 32'h0369d034);
    end
    i_angle_ack = 1'b1;
    step();
    check("resume", i_angle_dat, 32'h59e26af0);

    // Disable while stalled -> drain, then clear and re-enable
    i_angle_ack = 1'b0;
    cfg_write(ADR_CTRL, 32'h0);
    check("dis_hold", i_angle_dat, 32'h59e26af0);
    step();
    check("drain_req", {31'h0, i_angle_req}, 32'h1);
    step();
    check("drain_req2", {31'h0, i_angle_req}, 32'h1);
    check("drain_dat", i_angle_dat, 32'h59e26af0);
    i_angle_ack = 1'b1;
    step();
    check("drain_done", {31'h0, i_angle_req}, 32'h0);
    cfg_write(ADR_PHASE, 32'h12345678);
    cfg_write(ADR_CTRL, 32'h4);
    check("clr_dat", i_angle_dat, 32'h12345678);
    check("clr_req", {31'h0, i_angle_req}, 32'h0);
    cfg_write(ADR_CTRL, 32'h1);
    step();
    check("reen_req", {31'h0, i_angle_req}, 32'h1);
    check("reen_dat", i_angle_dat, 32'h12345678);
    step();
    check("reen_next", i_angle_dat, 32'h68acf134);

    // Asynchronous reset mid-stream with a pending word
    i_angle_ack = 1'b0;
    step();
    check("pre_rst_dat", i_angle_dat, 32'h68acf134);
    reset_n = 1'b0;
    #1;
    check("async_req", {31'h0, i_angle_req}, 32'h0);
    check("async_dat", i_angle_dat, 32'h0);
    check("async_ack", {31'h0, t_cfg_ack}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    i_angle_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_idle", {31'h0, i_angle_req}, 32'h0);
    end

    // Frequency sweep, including a FREQ write coincident with a sweep step
    do_reset();
    cfg_write(ADR_FREQ, 32'h100);
    cfg_write(ADR_STEP, 32'h10);
    cfg_write(ADR_CTRL, 32'h3);
    step();
    check("sweep0", i_angle_dat, 32'h0);
    step();
    check("sweep1", i_angle_dat, 32'h100);
    step();
    check("sweep2", i_angle_dat, 32'h210);
    step();
    check("sweep3", i_angle_dat, 32'h330);
    cfg_write(ADR_FREQ, 32'h5);
    check("sweep4", i_angle_dat, 32'h460);
    step();
    check("freq_win", i_angle_dat, 32'h465);

    // Phase offset with modulo wrap
    do_reset();
    cfg_write(ADR_PHASE, 32'h80000000);
    cfg_write(ADR_FREQ, 32'h40000000);
    cfg_write(ADR_CTRL, 32'h1);
    step();
    check("wrap0", i_angle_dat, 32'h80000000);
    step();
    check("wrap1", i_angle_dat, 32'hc0000000);
    step();
    check("wrap2", i_angle_dat, 32'h00000000);
    step();
    check("wrap3", i_angle_dat, 32'h40000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
